// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, depths and sample limits for the FIR output stage
package fir_pkg;

  localparam int B_WIDTH_DEF    = 12;
  localparam int C_WIDTH_DEF    = 12;
  localparam int CHAIN_LAT_DEF  = 11;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic signed [B_WIDTH_DEF-1:0] SAMPLE_MAX = 12'sd2047;
  localparam logic signed [B_WIDTH_DEF-1:0] SAMPLE_MIN = -12'sd2048;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - single-clock output FIFO with occupancy count
module fir_out_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   not_empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_push   = push & ~full;
  assign do_pop    = pop & not_empty;
  assign pop_data  = not_empty ? mem[rd_ptr] : '0;

  // Power-of-two depth lets the pointers wrap by natural overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/fir_out_stage.sv
// rtl/fir_out_stage.sv - credit-controlled FIR output stage; FIR_OUT_SAT_EN selects saturation over wrap
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int B_WIDTH    = B_WIDTH_DEF,
  parameter int C_WIDTH    = C_WIDTH_DEF,
  parameter int CHAIN_LAT  = CHAIN_LAT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [C_WIDTH:0]   c_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [B_WIDTH-1:0] out_data,
  output logic                      sat_flag
);

  localparam int CW1 = C_WIDTH + 1;
  localparam int NW  = cnt_width(FIFO_DEPTH);

  logic                      accept;
  logic                      mark;
  logic [CHAIN_LAT-1:0]      vsr;
  logic [NW-1:0]             inflight;
  logic [NW-1:0]             fifo_count;
  logic signed [B_WIDTH-1:0] conv;
  logic [B_WIDTH-1:0]        fifo_rd;

  // Credits cover results still in the MAC chain plus those already buffered
  assign in_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < (NW+1)'(FIFO_DEPTH);
  assign accept   = in_valid & in_ready;
  assign mark     = vsr[CHAIN_LAT-1];
  assign out_data = fifo_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsr      <= '0;
      inflight <= '0;
    end else begin
      vsr <= (vsr << 1) | CHAIN_LAT'(accept);
      case ({accept, mark})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

`ifdef FIR_OUT_SAT_EN
  logic clamp;

  if (CW1 <= B_WIDTH) begin : g_ext
    assign conv  = B_WIDTH'(c_in);
    assign clamp = 1'b0;
  end else begin : g_sat
    localparam logic signed [CW1-1:0] MAX_C = {{(CW1-B_WIDTH+1){1'b0}}, {(B_WIDTH-1){1'b1}}};
    localparam logic signed [CW1-1:0] MIN_C = {{(CW1-B_WIDTH+1){1'b1}}, {(B_WIDTH-1){1'b0}}};
    assign clamp = (c_in > MAX_C) || (c_in < MIN_C);
    assign conv  = (c_in > MAX_C) ? B_WIDTH'(MAX_C) :
                   (c_in < MIN_C) ? B_WIDTH'(MIN_C) : B_WIDTH'(c_in);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              sat_flag <= 1'b0;
    else if (mark && clamp) sat_flag <= 1'b1;
  end
`else
  // The cast sign-extends when widening and keeps the low bits when narrowing
  assign conv     = B_WIDTH'(c_in);
  assign sat_flag = 1'b0;
`endif

  fir_out_fifo #(
    .WIDTH (B_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (mark),
    .push_data (conv),
    .pop       (out_ready),
    .pop_data  (fifo_rd),
    .not_empty (out_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_fir_out_stage.sv
// tb/tb_fir_out_stage.sv - scoreboard bench for fir_out_stage (FIR_OUT_SAT_EN aware)
module tb_fir_out_stage;
  import fir_pkg::*;

  localparam int BW    = B_WIDTH_DEF;
  localparam int CW    = C_WIDTH_DEF;
  localparam int LAT   = CHAIN_LAT_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;
`ifdef FIR_OUT_SAT_EN
  localparam logic SAT_ON = 1'b1;
`else
  localparam logic SAT_ON = 1'b0;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW:0]   c_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BW-1:0] out_data;
  logic                 sat_flag;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int dl_val[LAT];
  bit dl_vld[LAT];
  int samp;
  int accepts;
  int pops;
  int seen;
  logic signed [BW-1:0] hold;

  always #5 clock = ~clock;

  fir_out_stage dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_flag  (sat_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int conv(input int v);
    logic [31:0] t;
    t = v;
    if (SAT_ON) begin
      if (v > (1 << (BW-1)) - 1) return (1 << (BW-1)) - 1;
      if (v < -(1 << (BW-1)))    return -(1 << (BW-1));
    end
    return int'($signed(t[BW-1:0]));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LAT; i++) begin
      dl_vld[i] = 1'b0;
      dl_val[i] = 0;
    end
    exp_q.delete();
  endtask

  // One clock: score outputs at the negedge, then advance the chain model
  task automatic tick();
    bit acc;
    int s;
    bit have;
    @(negedge clock);
    acc = in_valid && in_ready && !reset;
    s   = samp;
    if (acc) begin
      accepts++;
      exp_q.push_back(conv(s));
    end
    if (out_valid && out_ready) begin
      pops++;
      have = (exp_q.size() != 0);
      check("out_expected", have, 1);
      if (have) check("out_data", out_data, exp_q.pop_front());
    end
    @(posedge clock);
    #1;
    for (int i = LAT-1; i > 0; i--) begin
      dl_vld[i] = dl_vld[i-1];
      dl_val[i] = dl_val[i-1];
    end
    dl_vld[0] = acc;
    dl_val[0] = s;
    c_in = dl_vld[LAT-1] ? (CW+1)'(dl_val[LAT-1]) : (CW+1)'($urandom);
    samp = int'($urandom_range(8191)) - 4096;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = '0; samp = 0;
    accepts = 0; pops = 0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick();

    // single sample: valid exactly CHAIN_LAT+1 cycles after accept
    samp = 100; in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (LAT-1) tick();
    check("lat_early", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 100);
    out_ready = 1'b1; tick();
    check("single_drained", out_valid, 0);
    check("sat_clear", sat_flag, 0);

    // overflow handling
    samp = 2500;  in_valid = 1'b1; tick();
    samp = -3000; tick();
    samp = 777;   tick();
    in_valid = 1'b0;
    repeat (16) tick();
    check("sat_drain", exp_q.size(), 0);
    check("sat_flag", sat_flag, SAT_ON);

    // backpressure and stall hold
    out_ready = 1'b0; in_valid = 1'b1; accepts = 0;
    repeat (LAT+2) tick();
    check("bp_accepts", accepts, DEPTH);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_first", out_data, exp_q[0]);
    hold = out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", out_data, hold);
    end
    in_valid = 1'b0; out_ready = 1'b1; pops = 0;
    repeat (20) tick();
    check("bp_pops", pops, DEPTH);
    check("bp_recover", in_ready, 1);
    check("bp_empty", exp_q.size(), 0);

    // streaming: each credit round-trips in CHAIN_LAT+2 cycles
    in_valid = 1'b1; accepts = 0;
    repeat (8*(LAT+2)) tick();
    in_valid = 1'b0;
    check("stream_accepts", accepts, 8*DEPTH);
    repeat (20) tick();
    check("stream_empty", exp_q.size(), 0);

    // reset with samples in flight
    accepts = 0; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    clear_model();
    tick();
    check("rst_mid_in_ready", in_ready, 1);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen++;
    end
    check("rst_mid_accepts", accepts, 3);
    check("rst_mid_no_out", seen, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_sat", sat_flag, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
